mac_result_drain: RTL and testbench
===================================

Name: mac_result_drain

Overview:
- Read-out end of the 4x4 MAC array: snapshots the array's `acc[ROWS][COLS]` result matrix on a start request.
- Streams the snapshot out as one element per beat on a valid/ready stream, row-major, with a last flag.
- Optionally narrows each element with signed saturation.
- Sits between `mac_array_4x4` and the downstream AXI-Stream/DMA path; can pulse a clear back to the array after the final beat.

Parameters:
- ROWS, 4, array rows
- COLS, 4, array columns
- ACC_W, 32, signed accumulator width from the array
- OUT_W, 32, signed output element width (saturating narrow if less than ACC_W; sign-extend if greater)
- CLR_ON_DONE, 1, 1 = pulse acc_clr in the DONE cycle; 0 = acc_clr held 0

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request drain; sampled only in IDLE
- acc  in  signed [ACC_W-1:0] x [ROWS][COLS]  result matrix from the MAC array
- busy  out  1  high in STREAM and DONE
- done  out  1  one-cycle pulse after the last beat is accepted
- acc_clr  out  1  one-cycle clear request to the array (coincident with done when CLR_ON_DONE=1)
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream ready
- m_data  out  signed [OUT_W-1:0]  current element
- m_last  out  1  high on the final element (index ROWS*COLS-1)
- m_idx  out  $clog2(ROWS*COLS)  flat row-major index of the current element (r*COLS+c)

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - busy, done, acc_clr, m_valid, m_last = 0; m_data = 0; m_idx = 0.
  - Snapshot buffer cleared to 0.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - m_valid = 0.
  - On a posedge with start=1: copy all ROWS*COLS acc elements into the internal buffer on that same edge; idx <= 0; go to STREAM.
- STREAM:
  - m_valid = 1; m_data = sat(buf[idx]); m_idx = idx; m_last = (idx == ROWS*COLS-1).
  - Handshake:
    - A beat transfers on a posedge with m_valid && m_ready.
    - idx advances by 1 per transfer.
    - While m_valid && !m_ready, m_data, m_idx and m_last hold stable.
    - m_valid never drops before the transfer completes.
  - On transfer with m_last=1: go to DONE. idx wraps to 0.
- DONE (exactly one cycle):
  - done = 1; acc_clr = CLR_ON_DONE; m_valid = 0.
  - Next state is IDLE unconditionally.
- Latency and throughput:
  - First m_valid is asserted in the cycle after start is sampled.
  - With m_ready held high, the 16 beats occupy 16 consecutive cycles, and done is asserted in cycle 17 after start.
- Snapshot isolation: changes on acc after the start edge do not affect streamed data.
- start while busy (STREAM or DONE) is ignored; it is not queued.
- start asserted in the same cycle as done is ignored. A new drain needs start in IDLE, so the earliest restart is one cycle after done.
- Saturation, sat(x):
  - OUT_W < ACC_W: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - OUT_W == ACC_W: pass-through.
  - OUT_W > ACC_W: sign-extend.
  - Purely combinational on the buffer read path; no added latency.
- Reset asserted mid-stream: outputs drop to reset values immediately (async). No done or acc_clr is produced. The partial stream is abandoned.
- All outputs are registered or decoded from registered state only; no combinational path from m_ready to m_valid.

Decomposition:
- Shared package `mac_pkg` holds:
  - ROWS/COLS/ACC_W defaults
  - `acc_t` (signed [ACC_W-1:0])
  - `drain_state_e` enum {IDLE, STREAM, DONE}
  - a `sat_narrow` function (parameterised by OUT_W via a localparam-sized wrapper)
- No sub-module required. The snapshot buffer plus index mux stays inline.

Test Plan:
1. Reset then drain with m_ready=1, acc[0][0]=12, all others 0:
   - m_valid rises 1 cycle after start.
   - Beat 0 has data=12, idx=0.
   - Beats 1..15 have data=0; m_last only on idx 15.
   - done and acc_clr pulse exactly once, in cycle 17.
2. acc[r][c] = r*4+c-8 (range -8..7); change acc to all 99 the cycle after start:
   - Streamed sequence is -8..7 in order; no 99 appears.
3. Backpressure: m_ready toggles 1,0,0,1,... with acc[1][2]=-2:
   - m_data, m_idx and m_last stay stable while stalled.
   - Idx 6 carries -2.
   - Total beats = 16, none duplicated or dropped.
4. OUT_W=8: acc[0][0]=300, acc[0][1]=-300, acc[0][2]=-128, acc[0][3]=127:
   - Outputs are 127, -128, -128, 127.
5. start pulsed during beat 5 and again on the done cycle:
   - Both ignored; exactly one 16-beat stream and one done.
   - A start one cycle after done begins a new stream.
6. Assert rst_n=0 at beat 7:
   - m_valid, busy and m_data go to 0 immediately; done and acc_clr never pulse.
   - After release, a new start streams from idx 0.

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC array read-out path.
//   - ROWS_DEF / COLS_DEF / ACC_W_DEF : default array geometry and width
//   - acc_t                           : signed accumulator element type
//   - drain_state_e                   : drain controller states
//   - sat_narrow()                    : signed clamp of a wide value to out_w
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int ROWS_DEF  = 4;
    localparam int COLS_DEF  = 4;
    localparam int ACC_W_DEF = 32;

    // Working width for saturation; any ACC_W/OUT_W up to this is supported.
    localparam int SAT_W = 64;

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } drain_state_e;

    // Clamp x into [-2^(out_w-1), 2^(out_w-1)-1]. Callers size the result
    // down to out_w bits; a target as wide as SAT_W needs no clamping.
    function automatic logic signed [SAT_W-1:0] sat_narrow(
        input logic signed [SAT_W-1:0] x,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        if (out_w >= SAT_W) begin
            return x;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/mac_result_drain.sv
// -----------------------------------------------------------------------------
// mac_result_drain
// Snapshots the MAC array result matrix on start and streams it out row-major,
// one element per valid/ready beat, optionally saturating each element to
// OUT_W bits. A one-cycle done (and optional acc_clr) follows the last beat.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : drain request, honoured only in IDLE
//   acc[ROWS][COLS] : signed result matrix from the array
//   busy            : high while streaming and in the done cycle
//   done            : one-cycle pulse after the final beat is accepted
//   acc_clr         : one-cycle array clear request (with done if CLR_ON_DONE)
//   m_valid/m_ready : output stream handshake
//   m_data          : current element, saturated/sign-extended to OUT_W
//   m_last          : high on the final element
//   m_idx           : flat row-major index r*COLS+c of the current element
// -----------------------------------------------------------------------------
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int COLS        = COLS_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int OUT_W       = 32,
    parameter int CLR_ON_DONE = 1,
    localparam int N_ELEM     = ROWS * COLS,
    localparam int IDX_W      = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] acc [ROWS][COLS],
    output logic                    busy,
    output logic                    done,
    output logic                    acc_clr,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic                    m_last,
    output logic [IDX_W-1:0]        m_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    drain_state_e            state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] snap_q [N_ELEM];
    logic signed [ACC_W-1:0] snap_d [N_ELEM];

    // Narrow with saturation, pass through, or sign-extend, depending on
    // the relation of OUT_W to ACC_W. Purely combinational.
    function automatic logic signed [OUT_W-1:0] sat_elem(
        input logic signed [ACC_W-1:0] x
    );
        logic signed [SAT_W-1:0] wide;
        wide = SAT_W'(x);
        if (OUT_W < ACC_W) begin
            wide = sat_narrow(wide, OUT_W);
        end
        return OUT_W'(wide);
    endfunction

    // ---------------------------------------------------------------- state reg
    // NOTE: the snapshot is reset along with the control state, so every
    // element has a defined value even if it is read before the first start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < N_ELEM; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < N_ELEM; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        // NOTE: hold-by-default assignments keep this block latch-free.
        state_d = state_q;
        idx_d   = idx_q;
        for (int i = 0; i < N_ELEM; i++) begin
            snap_d[i] = snap_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            snap_d[r*COLS + c] = acc[r][c];
                        end
                    end
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // m_valid is implied by STREAM, so m_ready alone marks a transfer.
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // Decoded from registered state only; m_ready never reaches m_valid.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        acc_clr = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_idx   = '0;

        unique case (state_q)
            STREAM: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = sat_elem(snap_q[idx_q]);
                m_idx   = idx_q;
                m_last  = (idx_q == LAST_IDX);
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                acc_clr = (CLR_ON_DONE != 0);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// -----------------------------------------------------------------------------
// tb_mac_result_drain
// Directed bench for mac_result_drain. Two instances share all inputs: one
// with OUT_W=32 (pass-through) and one with OUT_W=8 (saturating narrow).
// -----------------------------------------------------------------------------
module tb_mac_result_drain;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               m_ready;
    logic signed [31:0] acc [4][4];

    logic               busy, done, acc_clr, m_valid, m_last;
    logic signed [31:0] m_data;
    logic [3:0]         m_idx;

    logic               busy8, done8, acc_clr8, m_valid8, m_last8;
    logic signed [7:0]  m_data8;
    logic [3:0]         m_idx8;

    mac_result_drain #(.OUT_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .acc(acc),
        .busy(busy), .done(done), .acc_clr(acc_clr),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_idx(m_idx)
    );

    mac_result_drain #(.OUT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .acc(acc),
        .busy(busy8), .done(done8), .acc_clr(acc_clr8),
        .m_valid(m_valid8), .m_ready(m_ready), .m_data(m_data8),
        .m_last(m_last8), .m_idx(m_idx8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-drain capture
    longint got_d32[$];
    longint got_d8[$];
    longint got_idx[$];
    longint got_last[$];
    int     done_cycle;
    int     done_pulses;
    int     clr_pulses;

    typedef struct {
        logic signed [31:0] a;
        logic signed [31:0] e32;
        logic signed [7:0]  e8;
    } sat_vec_t;

    sat_vec_t sat_tbl [16];

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_acc_all(input int v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                acc[r][c] = v;
    endtask

    // Drive start for one edge; returns #1 after that edge.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Run one drain from the cycle after start.
    //   ready_mode 0: m_ready always 1; 1: pattern 1,0,0 repeating
    //   start_beat: raise start while that beat index is presented (-1 none)
    //   start_on_done: raise start during the done cycle
    //   abort_beat: assert reset while that beat is presented (-1 none)
    task automatic collect(input int ready_mode, input int start_beat,
                           input bit start_on_done, input int abort_beat);
        bit     stalled_prev;
        longint prev_d, prev_i, prev_l;
        bit     finished;
        got_d32.delete(); got_d8.delete(); got_idx.delete(); got_last.delete();
        done_cycle   = -1;
        done_pulses  = 0;
        clr_pulses   = 0;
        stalled_prev = 1'b0;
        prev_d = 0; prev_i = 0; prev_l = 0;
        finished = 1'b0;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 1);
            start   = (start_beat >= 0 && got_d32.size() == start_beat && m_valid);
            if (abort_beat >= 0 && m_valid && got_d32.size() == abort_beat) begin
                rst_n = 1'b0;
                #1;
                check("abort m_valid", m_valid, 0);
                check("abort busy", busy, 0);
                check("abort m_data", m_data, 0);
                check("abort m_idx", m_idx, 0);
                start = 1'b0;
                return;
            end
            if (stalled_prev && m_valid) begin
                check("stall data stable", m_data, prev_d);
                check("stall idx stable", m_idx, prev_i);
                check("stall last stable", m_last, prev_l);
            end
            if (done) begin
                done_pulses++;
                if (done_cycle < 0) done_cycle = cyc;
                if (start_on_done) start = 1'b1;
                finished = 1'b1;
            end
            if (acc_clr) clr_pulses++;
            if (m_valid && m_ready) begin
                got_d32.push_back(m_data);
                got_d8.push_back(m_data8);
                got_idx.push_back(m_idx);
                got_last.push_back(m_last);
            end
            stalled_prev = m_valid && !m_ready;
            prev_d = m_data; prev_i = m_idx; prev_l = m_last;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!finished) check("drain timeout (done seen)", 0, 1);
        // One more cycle so a stray second done/acc_clr would be counted.
        if (done) done_pulses++;
        if (acc_clr) clr_pulses++;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        set_acc_all(0);

        // ---------------------------------------------------------- reset state
        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset acc_clr", acc_clr, 0);
        check("reset m_valid", m_valid, 0);
        check("reset m_last", m_last, 0);
        check("reset m_data", m_data, 0);
        check("reset m_idx", m_idx, 0);
        check("reset m_valid8", m_valid8, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ------------------------------------------- test 1: single nonzero
        acc[0][0] = 12;
        check("t1 idle m_valid", m_valid, 0);
        do_start();
        check("t1 m_valid after start", m_valid, 1);
        check("t1 busy after start", busy, 1);
        collect(0, -1, 1'b0, -1);
        check("t1 beats", got_d32.size(), 16);
        for (int i = 0; i < 16 && i < got_d32.size(); i++) begin
            check($sformatf("t1 data[%0d]", i), got_d32[i], (i == 0) ? 12 : 0);
            check($sformatf("t1 idx[%0d]", i), got_idx[i], i);
            check($sformatf("t1 last[%0d]", i), got_last[i], (i == 15) ? 1 : 0);
        end
        check("t1 done cycle", done_cycle, 17);
        check("t1 done pulses", done_pulses, 1);
        check("t1 acc_clr pulses", clr_pulses, 1);
        check("t1 idle after done", busy, 0);

        // ------------------------------------- test 2: snapshot isolation
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                acc[r][c] = r*4 + c - 8;
        do_start();
        set_acc_all(99);
        collect(0, -1, 1'b0, -1);
        check("t2 beats", got_d32.size(), 16);
        for (int i = 0; i < 16 && i < got_d32.size(); i++) begin
            check($sformatf("t2 data[%0d]", i), got_d32[i], i - 8);
            check($sformatf("t2 data8[%0d]", i), got_d8[i], i - 8);
        end

        // ------------------------------------------- test 3: backpressure
        set_acc_all(0);
        acc[1][2] = -2;
        do_start();
        collect(1, -1, 1'b0, -1);
        check("t3 beats", got_d32.size(), 16);
        for (int i = 0; i < 16 && i < got_d32.size(); i++) begin
            check($sformatf("t3 idx[%0d]", i), got_idx[i], i);
            check($sformatf("t3 data[%0d]", i), got_d32[i], (i == 6) ? -2 : 0);
        end
        check("t3 done pulses", done_pulses, 1);

        // --------------------------------- test 4: saturation vector table
        sat_tbl[0]  = '{a:  300,          e32:  300,          e8:  127};
        sat_tbl[1]  = '{a: -300,          e32: -300,          e8: -128};
        sat_tbl[2]  = '{a: -128,          e32: -128,          e8: -128};
        sat_tbl[3]  = '{a:  127,          e32:  127,          e8:  127};
        sat_tbl[4]  = '{a:  128,          e32:  128,          e8:  127};
        sat_tbl[5]  = '{a: -129,          e32: -129,          e8: -128};
        sat_tbl[6]  = '{a:  0,            e32:  0,            e8:  0};
        sat_tbl[7]  = '{a: -1,            e32: -1,            e8: -1};
        sat_tbl[8]  = '{a:  32'sh7FFFFFFF, e32: 32'sh7FFFFFFF, e8: 127};
        sat_tbl[9]  = '{a:  32'sh80000000, e32: 32'sh80000000, e8: -128};
        sat_tbl[10] = '{a:  255,          e32:  255,          e8:  127};
        sat_tbl[11] = '{a: -127,          e32: -127,          e8: -127};
        sat_tbl[12] = '{a:  126,          e32:  126,          e8:  126};
        sat_tbl[13] = '{a:  256,          e32:  256,          e8:  127};
        sat_tbl[14] = '{a: -256,          e32: -256,          e8: -128};
        sat_tbl[15] = '{a:  5,            e32:  5,            e8:  5};
        for (int i = 0; i < 16; i++) acc[i/4][i%4] = sat_tbl[i].a;
        do_start();
        collect(0, -1, 1'b0, -1);
        check("t4 beats", got_d32.size(), 16);
        for (int i = 0; i < 16 && i < got_d32.size(); i++) begin
            check($sformatf("t4 data32[%0d]", i), got_d32[i], sat_tbl[i].e32);
            check($sformatf("t4 data8[%0d]", i), got_d8[i], sat_tbl[i].e8);
        end

        // ----------------------- test 5: start while busy / on done ignored
        for (int i = 0; i < 16; i++) acc[i/4][i%4] = i + 1;
        do_start();
        collect(0, 5, 1'b1, -1);
        check("t5 beats", got_d32.size(), 16);
        check("t5 done pulses", done_pulses, 1);
        check("t5 start on done ignored (m_valid)", m_valid, 0);
        check("t5 start on done ignored (busy)", busy, 0);
        do_start();
        check("t5 restart m_valid", m_valid, 1);
        check("t5 restart m_idx", m_idx, 0);
        collect(0, -1, 1'b0, -1);
        check("t5 restart beats", got_d32.size(), 16);
        if (got_d32.size() == 16) check("t5 restart last data", got_d32[15], 16);

        // ------------------------------------------ test 6: reset mid-stream
        do_start();
        collect(0, -1, 1'b0, 7);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t6 no done in reset", done, 0);
            check("t6 no acc_clr in reset", acc_clr, 0);
            check("t6 m_valid in reset", m_valid, 0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6 idle after release", m_valid, 0);
        check("t6 no done after release", done, 0);
        do_start();
        check("t6 restart idx", m_idx, 0);
        check("t6 restart data", m_data, 1);
        collect(0, -1, 1'b0, -1);
        check("t6 restart beats", got_d32.size(), 16);
        check("t6 restart done pulses", done_pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
